// File: rtl/rx_frame_controller.sv
// UART receive sequencer: turns each rxReady rise into one parity-checked frame and
// buffers it in a small FIFO with a valid/accept handshake and sticky error flags.
module rx_frame_controller #(
    parameter int DEPTH    = 4,
    parameter bit DROP_BAD = 1'b0
) (
    input  logic                   baudOut,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [1:0]             parityMode,
    input  logic [8:0]             rxDataParity,
    input  logic                   rxReady,
    output logic [7:0]             dataOut,
    output logic                   dataErr,
    output logic                   dataValid,
    input  logic                   dataAccept,
    output logic [$clog2(DEPTH):0] fifoCount,
    output logic                   parityErr,
    output logic                   overrunErr,
    input  logic                   clearErr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, CHECK, STORE} state_t;

    state_t          state_q, state_d;
    logic            rx_ready_d;
    logic [8:0]      frame_reg;
    logic            err_reg;
    logic [8:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            parity_err, overrun_err;

    logic evt, full, pop, push, keep, store_ovf, lost;
    logic latch, do_check, do_store, calc_err, ones;

    assign evt  = rxReady & ~rx_ready_d;
    assign full = (count == FULL_CNT);
    assign pop  = (count != '0) & dataAccept;

    // Frames arriving while a previous one is still being checked/stored are lost.
    always_comb begin
        state_d  = state_q;
        latch    = 1'b0;
        do_check = 1'b0;
        do_store = 1'b0;
        lost     = 1'b0;
        case (state_q)
            IDLE: begin
                if (evt && enable) begin
                    latch   = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                do_check = 1'b1;
                lost     = evt & enable;
                state_d  = STORE;
            end
            STORE: begin
                do_store = 1'b1;
                lost     = evt & enable;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ones = ^frame_reg[7:0];
        case (parityMode)
            2'b01:   calc_err = (ones != frame_reg[8]);
            2'b10:   calc_err = (ones == frame_reg[8]);
            default: calc_err = 1'b0;
        endcase
    end

    // A full FIFO still accepts a push when the head is popped on the same clock.
    assign keep      = do_store & ~(DROP_BAD & err_reg);
    assign push      = keep & (~full | pop);
    assign store_ovf = keep & full & ~pop;

    always_ff @(posedge baudOut or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge baudOut or negedge rst) begin
        if (!rst) begin
            rx_ready_d  <= 1'b0;
            frame_reg   <= '0;
            err_reg     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            rx_ready_d <= rxReady;
            if (latch)    frame_reg <= rxDataParity;
            if (do_check) err_reg   <= calc_err;
            if (push) begin
                mem[wr_ptr] <= {err_reg, frame_reg[7:0]};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set beats clear when both happen on the same clock.
            parity_err  <= (parity_err & ~clearErr) | (do_store & err_reg);
            overrun_err <= (overrun_err & ~clearErr) | lost | store_ovf;
        end
    end

    assign dataOut    = mem[rd_ptr][7:0];
    assign dataErr    = mem[rd_ptr][8];
    assign dataValid  = (count != '0);
    assign fifoCount  = count;
    assign parityErr  = parity_err;
    assign overrunErr = overrun_err;
endmodule

// File: tb/tb_rx_frame_controller.sv
// Bench for rx_frame_controller: two instances (keep-bad and drop-bad) checked against
// a queue-based frame model under directed and random stimulus.
module tb_rx_frame_controller;
    localparam int DEPTH = 4;

    logic       baudOut = 1'b0;
    logic       rst, enable, rxReady, dataAccept, clearErr;
    logic [1:0] parityMode;
    logic [8:0] rxDataParity;

    logic [7:0] d0_out, d1_out;
    logic       d0_err, d1_err, d0_vld, d1_vld, d0_perr, d1_perr, d0_ovr, d1_ovr;
    logic [$clog2(DEPTH):0] d0_cnt, d1_cnt;

    int n_chk = 0, n_fail = 0;

    logic [8:0] q0[$], q1[$];
    bit perr, ovr0, ovr1;

    always #5 baudOut = ~baudOut;

    rx_frame_controller #(.DEPTH(DEPTH), .DROP_BAD(1'b0)) dut0 (
        .baudOut(baudOut), .rst(rst), .enable(enable), .parityMode(parityMode),
        .rxDataParity(rxDataParity), .rxReady(rxReady), .dataOut(d0_out), .dataErr(d0_err),
        .dataValid(d0_vld), .dataAccept(dataAccept), .fifoCount(d0_cnt),
        .parityErr(d0_perr), .overrunErr(d0_ovr), .clearErr(clearErr));

    rx_frame_controller #(.DEPTH(DEPTH), .DROP_BAD(1'b1)) dut1 (
        .baudOut(baudOut), .rst(rst), .enable(enable), .parityMode(parityMode),
        .rxDataParity(rxDataParity), .rxReady(rxReady), .dataOut(d1_out), .dataErr(d1_err),
        .dataValid(d1_vld), .dataAccept(dataAccept), .fifoCount(d1_cnt),
        .parityErr(d1_perr), .overrunErr(d1_ovr), .clearErr(clearErr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit bad_parity(input logic [7:0] d, input logic p, input logic [1:0] m);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        if (m == 2'b01) return (ones % 2) != p;
        if (m == 2'b10) return (ones % 2) == p;
        return 1'b0;
    endfunction

    // Model a completed frame; pop_same means the head was accepted on the store clock.
    task automatic model_frame(input logic [7:0] d, input logic p, input logic [1:0] m,
                               input bit pop_same);
        bit e = bad_parity(d, p, m);
        if (e) perr = 1'b1;
        if (q0.size() == DEPTH && !pop_same) ovr0 = 1'b1;
        else begin
            if (pop_same && q0.size() > 0) void'(q0.pop_front());
            q0.push_back({e, d});
        end
        if (!e) begin
            if (q1.size() == DEPTH && !pop_same) ovr1 = 1'b1;
            else begin
                if (pop_same && q1.size() > 0) void'(q1.pop_front());
                q1.push_back({1'b0, d});
            end
        end else if (pop_same && q1.size() > 0) void'(q1.pop_front());
    endtask

    task automatic check_state(input string tag);
        chk({tag, " vld0"}, d0_vld, q0.size() != 0);
        chk({tag, " cnt0"}, d0_cnt, q0.size());
        chk({tag, " perr0"}, d0_perr, perr);
        chk({tag, " ovr0"}, d0_ovr, ovr0);
        if (q0.size() != 0) chk({tag, " head0"}, {d0_err, d0_out}, q0[0]);
        chk({tag, " vld1"}, d1_vld, q1.size() != 0);
        chk({tag, " cnt1"}, d1_cnt, q1.size());
        chk({tag, " perr1"}, d1_perr, perr);
        chk({tag, " ovr1"}, d1_ovr, ovr1);
        if (q1.size() != 0) chk({tag, " head1"}, {d1_err, d1_out}, q1[0]);
    endtask

    // Called at a negedge; returns at a negedge after the frame has been stored.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic [1:0] m,
                              input int hold);
        parityMode   = m;
        rxDataParity = {p, d};
        rxReady      = 1'b1;
        repeat (hold) @(negedge baudOut);
        rxReady = 1'b0;
        repeat (2) @(negedge baudOut);
        if (enable) model_frame(d, p, m, 1'b0);
    endtask

    task automatic pop_one(input string tag);
        check_state(tag);
        dataAccept = 1'b1;
        @(negedge baudOut);
        dataAccept = 1'b0;
        if (q0.size() > 0) void'(q0.pop_front());
        if (q1.size() > 0) void'(q1.pop_front());
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2 * DEPTH && (q0.size() > 0 || q1.size() > 0); i++) pop_one(tag);
        check_state({tag, " drained"});
    endtask

    task automatic clear_flags();
        clearErr = 1'b1;
        @(negedge baudOut);
        clearErr = 1'b0;
        perr = 1'b0; ovr0 = 1'b0; ovr1 = 1'b0;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; rxReady = 1'b0; dataAccept = 1'b0; clearErr = 1'b0;
        parityMode = 2'b00; rxDataParity = '0;
        perr = 1'b0; ovr0 = 1'b0; ovr1 = 1'b0;
        repeat (2) @(negedge baudOut);
        chk("reset out0", {d0_vld, d0_err, d0_out, d0_perr, d0_ovr}, 0);
        chk("reset cnt0", d0_cnt, 0);
        chk("reset out1", {d1_vld, d1_err, d1_out, d1_perr, d1_ovr}, 0);
        rst = 1'b1;
        @(negedge baudOut);

        // odd parity good frame, latency of three edges
        parityMode = 2'b10; rxDataParity = {1'b1, 8'h55}; rxReady = 1'b1;
        @(negedge baudOut); chk("lat E0", d0_vld, 0);
        @(negedge baudOut); chk("lat E1", d0_vld, 0);
        @(negedge baudOut); chk("lat E2", d0_vld, 1);
        repeat (13) @(negedge baudOut);
        rxReady = 1'b0;
        @(negedge baudOut);
        model_frame(8'h55, 1'b1, 2'b10, 1'b0);
        check_state("odd55");
        drain("odd55");

        // even parity bad frame: kept with flag in dut0, dropped in dut1
        send_frame(8'h55, 1'b1, 2'b01, 16);
        check_state("even55");
        drain("even55");
        clear_flags();
        check_state("cleared");

        // overflow: five frames, no accept
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 2'b00, 3);
        check_state("full");
        chk("overflow flag", d0_ovr, 1);
        drain("overflow");
        clear_flags();

        // full FIFO with accept on the store clock of 0xA5
        for (int i = 0; i < DEPTH; i++) send_frame(8'h11 + 8'(i), 1'b0, 2'b00, 2);
        parityMode = 2'b00; rxDataParity = {1'b0, 8'hA5}; rxReady = 1'b1;
        repeat (2) @(negedge baudOut);
        dataAccept = 1'b1;
        @(negedge baudOut);
        dataAccept = 1'b0; rxReady = 1'b0;
        model_frame(8'hA5, 1'b0, 2'b00, 1'b1);
        check_state("wrap push+pop");
        chk("wrap cnt", d0_cnt, DEPTH);
        drain("wrap");

        // disabled frame ignored
        enable = 1'b0;
        send_frame(8'h3C, 1'b0, 2'b01, 4);
        check_state("disabled");
        enable = 1'b1;

        // clearErr coincident with a parity error in STORE
        parityMode = 2'b01; rxDataParity = {1'b1, 8'h0F}; rxReady = 1'b1;
        repeat (2) @(negedge baudOut);
        clearErr = 1'b1;
        @(negedge baudOut);
        clearErr = 1'b0; rxReady = 1'b0;
        perr = 1'b0; ovr0 = 1'b0; ovr1 = 1'b0;
        model_frame(8'h0F, 1'b1, 2'b01, 1'b0);
        check_state("clear vs set");
        drain("clear vs set");

        // second rise while busy is lost and flagged
        parityMode = 2'b00; rxDataParity = {1'b0, 8'h77}; rxReady = 1'b1;
        @(negedge baudOut); rxReady = 1'b0;
        @(negedge baudOut); rxReady = 1'b1;
        @(negedge baudOut); rxReady = 1'b0;
        @(negedge baudOut);
        model_frame(8'h77, 1'b0, 2'b00, 1'b0);
        ovr0 = 1'b1; ovr1 = 1'b1;
        check_state("busy overrun");
        drain("busy overrun");

        // reset during CHECK
        send_frame(8'h42, 1'b0, 2'b00, 2);
        parityMode = 2'b00; rxDataParity = {1'b0, 8'h99}; rxReady = 1'b1;
        @(negedge baudOut);
        rst = 1'b0; rxReady = 1'b0;
        #1;
        q0.delete(); q1.delete(); perr = 1'b0; ovr0 = 1'b0; ovr1 = 1'b0;
        chk("midrst out0", {d0_vld, d0_err, d0_out, d0_perr, d0_ovr}, 0);
        chk("midrst out1", {d1_vld, d1_err, d1_out, d1_perr, d1_ovr}, 0);
        check_state("midrst");
        @(negedge baudOut);
        rst = 1'b1;
        @(negedge baudOut);
        send_frame(8'h81, 1'b1, 2'b01, 5);
        check_state("after rst");
        drain("after rst");

        // random traffic
        for (int it = 0; it < 80; it++) begin
            int op = int'($urandom_range(0, 9));
            enable = ($urandom_range(0, 9) != 0);
            if (op < 5)
                send_frame(8'($urandom), 1'($urandom), 2'($urandom), int'($urandom_range(1, 6)));
            else if (op < 8) begin
                if (q0.size() > 0 || q1.size() > 0) pop_one($sformatf("rnd%0d pop", it));
            end else if (op == 8) clear_flags();
            else @(negedge baudOut);
            check_state($sformatf("rnd%0d", it));
        end
        enable = 1'b1;
        drain("rnd end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
